regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with read bypass, hazard scoreboard and
//  post-reset zero-init sweep. Sits between decode/issue (reads, reservations) and
//  writeback (writes, releases). x0 reads zero; writes to x0 are discarded.
// PARAMETERS
//  XLEN      32  data width per register
//  NUM_REGS  32  architectural registers, power of two, >= 4
//  NUM_RD    2   read ports
//  NUM_WR    1   write ports; higher index wins on same-address collision
//  AW        $clog2(NUM_REGS)  derived address width, not overridable
// PORTS
//  clk        in   1            single clock, posedge
//  rst        in   1            asynchronous, active-high reset
//  init_done  out  1            1 once zero sweep finished
//  rd_addr    in   NUM_RD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data    out  NUM_RD*XLEN  read data, combinational
//  rd_busy    out  NUM_RD       1 = register has outstanding producer, data stale
//  wr_en      in   NUM_WR       write strobes
//  wr_addr    in   NUM_WR*AW    write addresses
//  wr_data    in   NUM_WR*XLEN  write data
//  rsv_en     in   1            reserve destination (issue of a producer)
//  rsv_addr   in   AW           register to mark busy
// BEHAVIOUR
//  Reset (async): state=INIT, init_ptr=1, busy[]=0, init_done=0; rd_data=0, rd_busy=0.
//  FSM INIT: each cycle array[init_ptr]<=0, init_ptr++; at init_ptr==NUM_REGS-1 write it
//   and go READY. Sweep = NUM_REGS-1 cycles after rst deasserts. init_done=1 in READY.
//  During INIT: wr_en/rsv_en ignored; rd_data=0, rd_busy=0 for all ports.
//  READY is terminal until rst. Reset mid-operation aborts all state and restarts INIT.
//  Write: on posedge, wr_en[j] && wr_addr[j]!=0 -> array[wr_addr[j]]<=wr_data[j].
//   Same address on several ports: highest j takes effect, others dropped.
//  Read (combinational, 0 cycle): addr 0 -> 0; else if any wr_en[j] hits addr -> winning
//   wr_data (bypass); else array[addr]. Written value visible from array next cycle.
//  Scoreboard busy[NUM_REGS], busy[0] tied 0:
//   - write port j with wr_en[j] clears busy[wr_addr[j]] next cycle (release).
//   - rsv_en sets busy[rsv_addr] next cycle; reserve beats release on same address.
//   - rsv_addr==0 ignored.
//  rd_busy[i] = busy[addr_i] & ~(any write this cycle to addr_i); bypassed data is valid.
//   A reserve in the same cycle is not reflected until next cycle.
//  No ready/valid back-pressure: all inputs sampled every READY cycle.
// STRUCTURE
//  Package rvcpu_pkg: XLEN, REG_ADDR_W, RF_INIT/RF_READY state encoding.
//  Sub-module regfile_scoreboard: busy vector, reserve/release priority, rd_busy gen.
//  Top holds array, init FSM, write-priority resolve and bypass muxes (generate loops).
// TESTING (defaults unless noted)
//  1 rst pulse mid-run -> init_done=0 immediately, rd_data=0; init_done rises exactly
//    31 cycles after deassert; all regs read 0 afterwards.
//  2 wr x5=0xDEADBEEF, read x5 same cycle -> bypass 0xDEADBEEF; next cycle from array.
//  3 NUM_WR=2: both ports write x7 (0x11, 0x22) -> x7 reads 0x22; write x0=0xFF -> x0 reads 0.
//  4 rsv x9 -> next cycle rd_busy=1; write x9=0x55 -> same cycle rd_busy=0, data 0x55;
//    busy cleared next cycle.
//  5 rsv x3 and write x3 same cycle -> rd_busy=0 that cycle, busy[3]=1 next cycle.
//  6 wr_en/rsv_en asserted during INIT -> no effect; all regs 0, busy 0 after init_done.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// Shared register-file constants and the init-sweep state encoding.
package rvcpu_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    // INIT sweeps the array to zero after reset; READY is the operating state.
    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of read, write and reservation signals between the pipeline and the register file.
// There is no back-pressure: the register file samples every input on every READY cycle,
// and rd_data / rd_busy are combinational functions of the current-cycle inputs.
interface regfile_mp_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);
    import rvcpu_pkg::*;

    localparam int AW = $clog2(NUM_REGS);

    logic                   init_done;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   rsv_en;
    logic [AW-1:0]          rsv_addr;
    rf_state_e              dbg_state;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  init_done, rd_data, rd_busy, dbg_state
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output init_done, rd_data, rd_busy, dbg_state
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reservations mark a register as having an outstanding producer,
// writebacks release it. Reservation wins over release on the same register.
module regfile_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Next busy vector: releases first, then reservations override them; x0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (en) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j]) begin
                    busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (rsv_en && (rsv_addr != '0)) begin
                busy_nxt[rsv_addr] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy register, cleared by reset so the sweep starts with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
        logic [AW-1:0] addr;
        logic          wr_hit;

        // A write landing this cycle supplies the data through the bypass, so it is not stale.
        always_comb begin
            addr   = rd_addr[gi*AW +: AW];
            wr_hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                    wr_hit = 1'b1;
                end
            end
        end

        assign rd_busy[gi] = en & busy[addr] & ~wr_hit;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, busy scoreboard and a
// zero-init sweep after reset. x0 always reads zero and ignores writes.
// The interface instance must be parameterised with the same XLEN/NUM_REGS/NUM_RD/NUM_WR.
module regfile_mp
    import rvcpu_pkg::*;
#(
    parameter int XLEN     = rvcpu_pkg::XLEN,
    parameter int NUM_REGS = rvcpu_pkg::NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [AW-1:0]     init_ptr;
    logic [AW-1:0]     init_ptr_nxt;
    logic              ready;
    logic [NUM_WR-1:0] wr_en_eff;

    logic [XLEN-1:0] mem [NUM_REGS];

    assign ready         = (state == RF_READY);
    assign wr_en_eff     = ready ? bus.wr_en : '0;
    assign bus.init_done = ready;
    assign bus.dbg_state = state;

    // Init FSM state and sweep pointer; the sweep starts at x1 since x0 is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RF_INIT;
            init_ptr <= AW'(1);
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    // Walk the pointer up to the last register, then settle in READY until the next reset.
    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        if (state == RF_INIT) begin
            init_ptr_nxt = init_ptr + AW'(1);
            if (init_ptr == LAST_REG) begin
                state_nxt    = RF_READY;
                init_ptr_nxt = init_ptr;
            end
        end
    end

    // Array writes: sweep zeros during INIT; in READY later ports overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (state == RF_INIT) begin
            mem[init_ptr] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_eff[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
                    mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        // Read mux: array value, overridden by the highest same-cycle writer, forced to 0 for x0/INIT.
        always_comb begin
            addr = bus.rd_addr[gi*AW +: AW];
            val  = mem[addr];
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_eff[j] && (bus.wr_addr[j*AW +: AW] == addr)) begin
                    val = bus.wr_data[j*XLEN +: XLEN];
                end
            end
            if (!ready || (addr == '0)) begin
                val = '0;
            end
        end

        assign bus.rd_data[gi*XLEN +: XLEN] = val;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .en       (ready),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .rd_addr  (bus.rd_addr),
        .rd_busy  (bus.rd_busy)
    );

endmodule
